chol_diag_acc: RTL

Upstream stage of the Cholesky square-root unit. Per diagonal element it computes d_j = A_jj - sum_{k<j} L_jk^2 in fixed point, then hands the clamped, non-negative result to the square-root stage. That stage's data_valid/data inputs connect directly to this block's out_valid/out_data.
Streaming L_jk terms arrive through a valid/ready handshake. The output is a single-cycle pulse with no backpressure, because the square-root stage samples at fixed latency.

---
 rtl/chol_diag_acc_if.sv | 38 +++
 rtl/chol_diag_acc.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/chol_diag_acc_if.sv
// chol_diag_acc_if: operand, L-term stream and result signals of the diagonal accumulator.
// The not_pd member exists only when CHOL_DIAG_NEG_FLAG_EN is defined.
interface chol_diag_acc_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 3
);
   logic              clken;
   logic              start;
   logic [DATA_W-1:0] a_diag;
   logic [CNT_W-1:0]  num_terms;
   logic              l_valid;
   logic [DATA_W-1:0] l_data;
   logic              l_ready;
   logic              busy;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
`ifdef CHOL_DIAG_NEG_FLAG_EN
   logic              not_pd;

   modport master (
      output clken, start, a_diag, num_terms, l_valid, l_data,
      input  l_ready, busy, out_valid, out_data, not_pd
   );
   modport slave (
      input  clken, start, a_diag, num_terms, l_valid, l_data,
      output l_ready, busy, out_valid, out_data, not_pd
   );
`else
   modport master (
      output clken, start, a_diag, num_terms, l_valid, l_data,
      input  l_ready, busy, out_valid, out_data
   );
   modport slave (
      input  clken, start, a_diag, num_terms, l_valid, l_data,
      output l_ready, busy, out_valid, out_data
   );
`endif
endinterface

// File: rtl/chol_diag_acc.sv
// chol_diag_acc: computes d_j = A_jj - sum(L_jk^2) in fixed point for one diagonal element and
// presents the clamped, non-negative result as a one-cycle pulse to the square-root stage.
// Optional macro CHOL_DIAG_NEG_FLAG_EN adds the sticky not_pd flag.
module chol_diag_acc #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned FRAC_W = 16,
   parameter int unsigned N_MAX  = 8
) (
   input logic            clk,
   input logic            rst,
   chol_diag_acc_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(N_MAX);
   // Wide enough that A_jj minus N_MAX full-range squares can never overflow.
   localparam int unsigned ACC_W = 2 * DATA_W + CNT_W + 1;
   localparam int unsigned SQ_W  = 2 * DATA_W;

   typedef enum logic [1:0] {StIdle, StAccum, StDrain, StEmit} state_e;

   state_e                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]        n_q, n_d;
   logic signed [SQ_W-1:0]  prod_q, prod_d;
   logic                    prod_v_q, prod_v_d;
`ifdef CHOL_DIAG_NEG_FLAG_EN
   logic                    not_pd_q, not_pd_d;
`endif

   logic signed [DATA_W-1:0] l_s;
   logic signed [SQ_W-1:0]   l_ext;
   logic signed [SQ_W-1:0]   l_sq;
   logic [31:0]              nt_wide;
   logic [CNT_W-1:0]         n_clamped;
   logic                     acc_le0;
   logic                     acc_big;

   // Full-precision square of the incoming term and saturation of the requested term count.
   always_comb begin
      l_s       = signed'(bus.l_data);
      l_ext     = SQ_W'(l_s);
      l_sq      = l_ext * l_ext;
      nt_wide   = 32'(bus.num_terms);
      n_clamped = (nt_wide > N_MAX - 1) ? CNT_W'(N_MAX - 1) : bus.num_terms;
   end

   // Next-state logic for the FSM, the accumulator and the product pipeline stage.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      n_d      = n_q;
      prod_d   = prod_q;
      prod_v_d = 1'b0;
`ifdef CHOL_DIAG_NEG_FLAG_EN
      not_pd_d = not_pd_q;
`endif

      // Subtraction of the registered square runs independently of the FSM state.
      if (prod_v_q) begin
         acc_d = acc_q - ACC_W'(prod_q);
      end

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               acc_d   = ACC_W'(bus.a_diag);
               cnt_d   = '0;
               n_d     = n_clamped;
               state_d = (n_clamped == '0) ? StEmit : StAccum;
`ifdef CHOL_DIAG_NEG_FLAG_EN
               not_pd_d = 1'b0;
`endif
            end
         end
         StAccum: begin
            if (bus.l_valid) begin
               // Arithmetic shift truncates the square toward -inf.
               prod_d   = l_sq >>> FRAC_W;
               prod_v_d = 1'b1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_d == n_q) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            state_d = StEmit;
         end
         StEmit: begin
            state_d = StIdle;
`ifdef CHOL_DIAG_NEG_FLAG_EN
            if (acc_le0) begin
               not_pd_d = 1'b1;
            end
`endif
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register; clken low freezes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         cnt_q    <= '0;
         n_q      <= '0;
         prod_q   <= '0;
         prod_v_q <= 1'b0;
`ifdef CHOL_DIAG_NEG_FLAG_EN
         not_pd_q <= 1'b0;
`endif
      end else if (bus.clken) begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         n_q      <= n_d;
         prod_q   <= prod_d;
         prod_v_q <= prod_v_d;
`ifdef CHOL_DIAG_NEG_FLAG_EN
         not_pd_q <= not_pd_d;
`endif
      end
   end

   // Clamp of the signed accumulator to the unsigned output range.
   always_comb begin
      acc_le0 = acc_q[ACC_W-1] | (acc_q == '0);
      acc_big = |acc_q[ACC_W-2:DATA_W];
   end

   assign bus.l_ready   = (state_q == StAccum);
   assign bus.busy      = (state_q != StIdle);
   assign bus.out_valid = (state_q == StEmit);
   assign bus.out_data  = acc_le0 ? '0 : (acc_big ? '1 : acc_q[DATA_W-1:0]);
`ifdef CHOL_DIAG_NEG_FLAG_EN
   assign bus.not_pd    = not_pd_q;
`endif

endmodule
